wash_phase_timer: RTL and testbench
===================================

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 The block SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 The block SHALL provide: reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-003 The block SHALL provide: program  input  2  wash program select; 00 normal, 01 heavy, 10 quick, 11 treated as normal.
REQ-004 The block SHALL provide: motor_on, soap_wash, water_wash, drain_valve_on, done  inputs  1 each  status outputs of the wash controller.
REQ-005 The block SHALL provide: pause  input  1  user pause; freezes the running timer.
REQ-006 The block SHALL provide: cycle_time_out  output  1  single-cycle pulse ending a soap-wash or rinse phase.
REQ-007 The block SHALL provide: spin_time_out  output  1  single-cycle pulse ending the spin phase.
REQ-008 The block SHALL provide: phase  output  3  encoded state: 0 IDLE, 1 SOAP, 2 RINSE, 3 SPIN, 4 WAIT_EXIT.
REQ-009 The block SHALL provide: remaining  output  8  current down-counter value.

Function
REQ-010 On entry to SOAP, the FSM SHALL latch program; the latched value SHALL hold until the FSM returns to IDLE.
REQ-011 Durations in clk cycles SHALL be: normal 40/20/16, heavy 80/40/32, quick 20/10/8 (soap/rinse/spin).
REQ-012 IDLE SHALL go to SOAP when motor_on=1 and soap_wash=1; the counter SHALL load the soap duration in the same edge.
REQ-013 IDLE SHALL go to RINSE when motor_on=1 and water_wash=1; the counter SHALL load the rinse duration.
REQ-014 IDLE SHALL go to SPIN when motor_on=1, drain_valve_on=1, soap_wash=0 and water_wash=0; the counter SHALL load the spin duration.
REQ-015 If soap_wash and water_wash are both 1 in IDLE, SOAP SHALL take priority.
REQ-016 In SOAP, RINSE and SPIN, the counter SHALL decrement by 1 on each cycle with motor_on=1 and pause=0, and SHALL hold otherwise.
REQ-017 The cycle in which remaining=1 decrements to 0 SHALL assert the phase's timeout on the next cycle for exactly one cycle, then enter WAIT_EXIT.
REQ-018 SOAP and RINSE SHALL use cycle_time_out; SPIN SHALL use spin_time_out.
REQ-019 The counter SHALL never wrap below 0; it SHALL hold 0 in WAIT_EXIT.
REQ-020 WAIT_EXIT SHALL return to IDLE once motor_on=0, allowing the next phase to be detected afresh.
REQ-021 If motor_on falls in SOAP/RINSE/SPIN before expiry, the FSM SHALL return to IDLE with no timeout pulse.
REQ-022 done=1 in any state SHALL force IDLE, clear the counter to 0 and suppress any pending pulse.
REQ-023 Timeout outputs SHALL be registered; cycle_time_out and spin_time_out SHALL never be asserted in the same cycle.

Reset
REQ-024 With reset=0: phase=IDLE, remaining=0, cycle_time_out=0, spin_time_out=0, latched program=00.
REQ-025 Reset asserted mid-phase SHALL abort the phase with no pulse; the first rising edge after reset release SHALL evaluate the IDLE transitions.

Configuration
REQ-026 With PAUSE_EN defined, the pause input SHALL gate counting as in REQ-016.
REQ-027 Without PAUSE_EN, pause SHALL be ignored and counting SHALL depend only on motor_on.

Verification
REQ-028 program=00; soap_wash=1, motor_on=1 held -> phase=1, remaining loads 40, cycle_time_out pulses once 41 cycles after entry, phase=4.
REQ-029 program=10; spin condition -> spin_time_out pulses once after 8 counted cycles; cycle_time_out stays 0.
REQ-030 With PAUSE_EN defined, heavy rinse with pause=1 for 15 cycles mid-run -> pulse delayed by exactly 15 cycles; remaining frozen during pause.
REQ-031 Normal soap; motor_on drops at remaining=5 -> phase=IDLE, no pulse.
REQ-032 reset=0 asynchronously at remaining=10 during RINSE -> all outputs at reset values before the next edge; no pulse after release.
REQ-033 done=1 during SPIN -> phase=IDLE, remaining=0 next edge; no spin_time_out.

Source files
------------

// File: rtl/wash_phase_timer_if.sv
// Bundle between the wash controller and the phase timer. The timer ports use
// the slave modport. The testbench or the controller uses the master modport.
interface wash_phase_timer_if;
  logic [1:0] program_sel;
  logic       motor_on;
  logic       soap_wash;
  logic       water_wash;
  logic       drain_valve_on;
  logic       done;
  logic       pause;

  // cycle_time_out and spin_time_out are registered, one-cycle pulses that are
  // never high together. There is no handshake: the consumer must sample every cycle.
  logic       cycle_time_out;
  logic       spin_time_out;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic [1:0] program_latched;

  modport master (
    output program_sel, motor_on, soap_wash, water_wash, drain_valve_on, done, pause,
    input  cycle_time_out, spin_time_out, phase, remaining, program_latched
  );

  modport slave (
    input  program_sel, motor_on, soap_wash, water_wash, drain_valve_on, done, pause,
    output cycle_time_out, spin_time_out, phase, remaining, program_latched
  );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase down-counter for a washing machine: it times soap, rinse and spin, then pulses a timeout.
// Define PAUSE_EN so that the pause input freezes the running counter.
module wash_phase_timer (
  input  logic                      clk,
  input  logic                      reset,
  wash_phase_timer_if.slave         bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOAP      = 3'd1,
    ST_RINSE     = 3'd2,
    ST_SPIN      = 3'd3,
    ST_WAIT_EXIT = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [1:0] prog_q, prog_d;
  logic       cyc_to_q, cyc_to_d;
  logic       spin_to_q, spin_to_d;
  logic       count_en;

  // Program code 2'b11 falls into the default arm, so it times like normal.
  function automatic logic [7:0] soap_dur(input logic [1:0] p);
    case (p)
      2'b01:   soap_dur = 8'd80;
      2'b10:   soap_dur = 8'd20;
      default: soap_dur = 8'd40;
    endcase
  endfunction

  function automatic logic [7:0] rinse_dur(input logic [1:0] p);
    case (p)
      2'b01:   rinse_dur = 8'd40;
      2'b10:   rinse_dur = 8'd10;
      default: rinse_dur = 8'd20;
    endcase
  endfunction

  function automatic logic [7:0] spin_dur(input logic [1:0] p);
    case (p)
      2'b01:   spin_dur = 8'd32;
      2'b10:   spin_dur = 8'd8;
      default: spin_dur = 8'd16;
    endcase
  endfunction

`ifdef PAUSE_EN
  assign count_en = bus.motor_on & ~bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign count_en     = bus.motor_on;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prog_d      = prog_q;
    cyc_to_d    = 1'b0;
    spin_to_d   = 1'b0;

    if (bus.done) begin
      state_d     = ST_IDLE;
      remaining_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          remaining_d = 8'd0;
          if (bus.motor_on) begin
            if (bus.soap_wash) begin
              state_d     = ST_SOAP;
              remaining_d = soap_dur(bus.program_sel);
              prog_d      = bus.program_sel;
            end else if (bus.water_wash) begin
              state_d     = ST_RINSE;
              remaining_d = rinse_dur(bus.program_sel);
              prog_d      = bus.program_sel;
            end else if (bus.drain_valve_on) begin
              state_d     = ST_SPIN;
              remaining_d = spin_dur(bus.program_sel);
              prog_d      = bus.program_sel;
            end
          end
        end

        // The counter reaches 0 on one edge and the pulse fires on the next edge.
        // Once the counter is 0 the phase has expired, so motor_on no longer aborts it.
        ST_SOAP, ST_RINSE, ST_SPIN: begin
          if (remaining_q == 8'd0) begin
            state_d = ST_WAIT_EXIT;
            if (state_q == ST_SPIN) spin_to_d = 1'b1;
            else                    cyc_to_d  = 1'b1;
          end else if (!bus.motor_on) begin
            state_d     = ST_IDLE;
            remaining_d = 8'd0;
          end else if (count_en) begin
            remaining_d = remaining_q - 8'd1;
          end
        end

        ST_WAIT_EXIT: begin
          remaining_d = 8'd0;
          if (!bus.motor_on) state_d = ST_IDLE;
        end

        default: begin
          state_d     = ST_IDLE;
          remaining_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      prog_q      <= 2'b00;
      cyc_to_q    <= 1'b0;
      spin_to_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      prog_q      <= prog_d;
      cyc_to_q    <= cyc_to_d;
      spin_to_q   <= spin_to_d;
    end
  end

  assign bus.phase           = state_q;
  assign bus.remaining       = remaining_q;
  assign bus.program_latched = prog_q;
  assign bus.cycle_time_out  = cyc_to_q;
  assign bus.spin_time_out   = spin_to_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer. The expected timeout pulses (kind and cycle)
// are queued when stimulus is issued, and a negedge monitor pops and compares them.
module tb_wash_phase_timer;

  localparam int W = 34;
  localparam logic [1:0] K_CYC  = 2'b01;
  localparam logic [1:0] K_SPIN = 2'b10;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  wash_phase_timer_if bus ();

  wash_phase_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= cyc;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input int at_cyc);
    exp_q.push_back({kind, at_cyc[31:0]});
  endtask

  task automatic drive_idle();
    bus.motor_on       = 1'b0;
    bus.soap_wash      = 1'b0;
    bus.water_wash     = 1'b0;
    bus.drain_valve_on = 1'b0;
    bus.done           = 1'b0;
    bus.pause          = 1'b0;
  endtask

  // monitor: each timeout pulse must match the head of the expected queue
  always @(negedge clk) begin
    logic [1:0]   kind;
    logic [W-1:0] e;
    if (reset && (bus.cycle_time_out || bus.spin_time_out)) begin
      kind = {bus.spin_time_out, bus.cycle_time_out};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, kind}, {30'd0, e[W-1:W-2]});
        check("pulse_cycle", cyc, e[31:0]);
      end
    end
  end

  initial begin
    int n0;
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    reset  = 1'b0;
    bus.program_sel = 2'b00;
    drive_idle();

    // reset state
    #12;
    check("rst_phase", {29'd0, bus.phase}, 0);
    check("rst_remaining", {24'd0, bus.remaining}, 0);
    check("rst_cto", {31'd0, bus.cycle_time_out}, 0);
    check("rst_sto", {31'd0, bus.spin_time_out}, 0);
    check("rst_prog", {30'd0, bus.program_latched}, 0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // normal soap: load 40, pulse 41 edges after entry
    bus.program_sel = 2'b00;
    bus.motor_on = 1'b1; bus.soap_wash = 1'b1;
    step(1);
    n0 = cyc;
    check("soap_phase", {29'd0, bus.phase}, 1);
    check("soap_load", {24'd0, bus.remaining}, 40);
    expect_pulse(K_CYC, n0 + 41);
    step(41);
    check("soap_wait_phase", {29'd0, bus.phase}, 4);
    check("soap_wait_rem", {24'd0, bus.remaining}, 0);
    step(3);
    check("wait_hold_phase", {29'd0, bus.phase}, 4);
    drive_idle();
    step(1);
    check("soap_exit_idle", {29'd0, bus.phase}, 0);

    // quick spin: load 8, spin pulse only
    bus.program_sel = 2'b10;
    bus.motor_on = 1'b1; bus.drain_valve_on = 1'b1;
    step(1);
    n0 = cyc;
    check("spin_q_phase", {29'd0, bus.phase}, 3);
    check("spin_q_load", {24'd0, bus.remaining}, 8);
    expect_pulse(K_SPIN, n0 + 9);
    step(12);
    check("spin_q_wait", {29'd0, bus.phase}, 4);
    drive_idle();
    step(2);

    // heavy rinse with 15 paused cycles mid-run
    bus.program_sel = 2'b01;
    bus.motor_on = 1'b1; bus.water_wash = 1'b1;
    step(1);
    n0 = cyc;
    check("rinse_h_load", {24'd0, bus.remaining}, 40);
    step(10);
    check("rinse_h_pre_pause", {24'd0, bus.remaining}, 30);
    bus.pause = 1'b1;
`ifdef PAUSE_EN
    expect_pulse(K_CYC, n0 + 41 + 15);
    step(15);
    check("rinse_h_frozen", {24'd0, bus.remaining}, 30);
`else
    expect_pulse(K_CYC, n0 + 41);
    step(15);
    check("rinse_h_no_freeze", {24'd0, bus.remaining}, 15);
`endif
    bus.pause = 1'b0;
    step(35);
    check("rinse_h_wait", {29'd0, bus.phase}, 4);
    drive_idle();
    step(2);

    // normal soap aborted by motor_on falling at remaining=5
    bus.program_sel = 2'b00;
    bus.motor_on = 1'b1; bus.soap_wash = 1'b1;
    step(36);
    check("abort_rem5", {24'd0, bus.remaining}, 5);
    bus.motor_on = 1'b0;
    step(1);
    check("abort_phase", {29'd0, bus.phase}, 0);
    check("abort_rem", {24'd0, bus.remaining}, 0);
    drive_idle();
    step(10);

    // asynchronous reset during normal rinse at remaining=10
    bus.motor_on = 1'b1; bus.water_wash = 1'b1;
    step(11);
    check("rst_mid_rem", {24'd0, bus.remaining}, 10);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_phase", {29'd0, bus.phase}, 0);
    check("rst_mid_remaining", {24'd0, bus.remaining}, 0);
    check("rst_mid_cto", {31'd0, bus.cycle_time_out}, 0);
    drive_idle();
    #1 reset = 1'b1;
    step(1);
    check("rst_rel_phase", {29'd0, bus.phase}, 0);
    step(25);

    // done during normal spin
    bus.motor_on = 1'b1; bus.drain_valve_on = 1'b1;
    step(6);
    check("done_spin_rem", {24'd0, bus.remaining}, 11);
    bus.done = 1'b1;
    step(1);
    check("done_phase", {29'd0, bus.phase}, 0);
    check("done_rem", {24'd0, bus.remaining}, 0);
    drive_idle();
    step(20);

    // soap wins over rinse; latched program ignores later changes
    bus.program_sel = 2'b10;
    bus.motor_on = 1'b1; bus.soap_wash = 1'b1; bus.water_wash = 1'b1;
    step(1);
    check("prio_phase", {29'd0, bus.phase}, 1);
    check("prio_load", {24'd0, bus.remaining}, 20);
    check("prio_latch", {30'd0, bus.program_latched}, 2);
    bus.program_sel = 2'b01;
    step(3);
    check("latch_hold", {30'd0, bus.program_latched}, 2);
    check("prio_count", {24'd0, bus.remaining}, 17);
    drive_idle();
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    step(1);
    check("prio_cleared", {29'd0, bus.phase}, 0);

    // program 11 times like normal spin
    bus.program_sel = 2'b11;
    bus.motor_on = 1'b1; bus.drain_valve_on = 1'b1;
    step(1);
    n0 = cyc;
    check("p11_load", {24'd0, bus.remaining}, 16);
    check("p11_latch", {30'd0, bus.program_latched}, 3);
    expect_pulse(K_SPIN, n0 + 17);
    step(17);
    check("p11_wait", {29'd0, bus.phase}, 4);
    drive_idle();
    step(5);

    check("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
